wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback requesters:
//  the ALU and the load (memory) unit. Uses fixed priority to the load unit.
//  A wait counter guarantees the ALU is never starved.
//  Output is a registered write command (write_en/rd/rd_val) that drives the
//  regfile write port directly.
// PARAMETERS
//  XLEN      32  datapath width of rd_val
//  MAX_WAIT  4   stalled-ALU cycles before ALU overrides load priority (>=1)
// PORTS
//  clk        in   1     clock; all logic on posedge
//  rst        in   1     synchronous, active-high reset
//  alu_valid  in   1     ALU has a writeback pending
//  alu_rd     in   5     ALU destination register
//  alu_val    in   XLEN  ALU result
//  alu_ready  out  1     ALU writeback accepted this cycle (comb.)
//  mem_valid  in   1     load unit has a writeback pending
//  mem_rd     in   5     load destination register
//  mem_val    in   XLEN  load data
//  mem_ready  out  1     load writeback accepted this cycle (comb.)
//  write_en   out  1     regfile write enable (registered)
//  rd         out  5     regfile write address (registered)
//  rd_val     out  XLEN  regfile write data (registered)
//  wb_src     out  1     source of current command: 0=ALU, 1=load (registered)
// BEHAVIOUR
//  - Handshake: a transfer occurs when valid && ready at posedge. Requesters hold
//    valid/rd/val stable until ready. ready never depends on rd/val.
//  - Starve flag: starve = (wait_cnt >= MAX_WAIT).
//  - Grant (combinational):
//    - mem_ready = mem_valid && !(alu_valid && starve).
//    - alu_ready = alu_valid && (!mem_valid || starve).
//    - At most one ready is high per cycle. Both are 0 while rst=1.
//  - wait_cnt, width $clog2(MAX_WAIT+1):
//    - Cleared on reset, on ALU acceptance, or when alu_valid=0.
//    - Otherwise, while alu_valid && !alu_ready, increments each cycle and
//      saturates at MAX_WAIT.
//  - Output register, latency 1:
//    - On the posedge that accepts a request, rd/rd_val/wb_src load the winner's
//      fields.
//    - write_en <= (winner rd != 0): an x0 writeback is consumed but not written.
//    - With no transfer, write_en <= 0; rd/rd_val/wb_src hold their last values.
//    - The regfile therefore commits on the following posedge. write_en is never
//      high for more than one cycle per transfer.
//  - Throughput: one writeback per cycle. Back-to-back grants are allowed with
//    no bubble.
//  - Simultaneous valid, starve=0: load wins, ALU waits, wait_cnt increments.
//    Simultaneous valid, starve=1: ALU wins, load waits (load has no counter,
//    since ALU grants after starve are single-shot).
//  - Reset (any cycle, including mid-stream): write_en=0, rd=0, rd_val=0,
//    wb_src=0, wait_cnt=0, both readys=0. A request in flight during reset is
//    not accepted. The requester must re-present it after reset.
// TESTING
//  1. Reset: rst=1 for 2 cycles with both valids high -> readys=0, write_en=0,
//     rd=0, rd_val=0 throughout.
//  2. Lone ALU: alu_valid=1, rd=5, val=32'hDEADBEEF for 1 cycle ->
//     alu_ready=1 that cycle; next cycle write_en=1, rd=5, rd_val=DEADBEEF,
//     wb_src=0; then write_en=0.
//  3. Conflict: both valid for 6 cycles (MAX_WAIT=4), load rd=1..n, ALU rd=9 ->
//     loads granted cycles 0-3; ALU granted cycle 4; a load is granted at cycle 5.
//  4. x0: mem_valid=1, mem_rd=0, mem_val=1 -> mem_ready=1; next cycle
//     write_en=0, wb_src=1.
//  5. Back-to-back: load writes rd=3,4,5 on consecutive cycles -> write_en held
//     high for 3 cycles with rd=3,4,5 in order.
//  6. Reset mid-stream: assert rst while ALU is starving with wait_cnt=3 ->
//     after release, ALU needs 4 more stalled cycles before override.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the regfile write port between the ALU and the load unit.
// Load has fixed priority; a wait counter lets a stalled ALU override it.
module wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_val,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_val,
  output logic            mem_ready,
  output logic            write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_val,
  output logic            wb_src
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic            en;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
    logic            src;
  } wb_cmd_t;

  logic [CW-1:0] wait_cnt;
  logic          starve;
  logic          alu_take;
  logic          mem_take;
  wb_cmd_t       cmd;
  wb_cmd_t       cmd_nxt;

  assign starve   = (wait_cnt >= CW'(MAX_WAIT));
  assign alu_take = alu_valid && (!mem_valid || starve);
  assign mem_take = mem_valid && !(alu_valid && starve);

  // Terms are mutually exclusive, so at most one ready fires.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    unique case (1'b1)
      !rst && alu_take: alu_ready = 1'b1;
      !rst && mem_take: mem_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !alu_valid || alu_ready)
      wait_cnt <= '0;
    else if (!starve)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // An x0 writeback is consumed but never enables the write.
  always_comb begin
    cmd_nxt    = cmd;
    cmd_nxt.en = 1'b0;
    unique case (1'b1)
      alu_ready: begin
        cmd_nxt.en  = (alu_rd != 5'd0);
        cmd_nxt.rd  = alu_rd;
        cmd_nxt.val = alu_val;
        cmd_nxt.src = 1'b0;
      end
      mem_ready: begin
        cmd_nxt.en  = (mem_rd != 5'd0);
        cmd_nxt.rd  = mem_rd;
        cmd_nxt.val = mem_val;
        cmd_nxt.src = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      cmd <= '0;
    else
      cmd <= cmd_nxt;
  end

  assign write_en = cmd.en;
  assign rd       = cmd.rd;
  assign rd_val   = cmd.val;
  assign wb_src   = cmd.src;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: vector table, corner sequences, random vs model.
// Expected values come from constants or from a waited-cycles reference model.
module tb_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_val;
  logic            alu_ready;
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_val;
  logic            mem_ready;
  logic            write_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_val;
  logic            wb_src;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_val(alu_val), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_val(mem_val), .mem_ready(mem_ready),
    .write_en(write_en), .rd(rd),
    .rd_val(rd_val), .wb_src(wb_src)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ALU wins a conflict only after waiting MAX_WAIT cycles.
  int              stall = 0;
  logic            e_ar, e_mr;
  logic            m_we = 1'b0;
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_val = '0;
  logic            m_src = 1'b0;

  task automatic model_pre();
    e_ar = 1'b0;
    e_mr = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        if (stall >= MAX_WAIT) e_ar = 1'b1;
        else e_mr = 1'b1;
      end else begin
        e_ar = alu_valid;
        e_mr = mem_valid;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_we = 1'b0;
    if (rst) begin
      m_rd = '0; m_val = '0; m_src = 1'b0; stall = 0;
    end else begin
      if (e_ar) begin
        m_we = (alu_rd != 0); m_rd = alu_rd; m_val = alu_val; m_src = 1'b0;
      end else if (e_mr) begin
        m_we = (mem_rd != 0); m_rd = mem_rd; m_val = mem_val; m_src = 1'b1;
      end
      stall = (alu_valid && !e_ar) ? stall + 1 : 0;
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard,
                       input logic [31:0] aval, input logic mv,
                       input logic [4:0] mrd, input logic [31:0] mval);
    rst = r; alu_valid = av; alu_rd = ard; alu_val = aval;
    mem_valid = mv; mem_rd = mrd; mem_val = mval;
    #1;
    model_pre();
  endtask

  typedef struct {
    logic r, av; logic [4:0] ard; logic [31:0] aval;
    logic mv; logic [4:0] mrd; logic [31:0] mval;
    logic ar, mr, we; logic [4:0] rd; logic [31:0] val; logic src;
  } vec_t;

  function automatic vec_t mk(
    logic r, logic av, logic [4:0] ard, logic [31:0] aval,
    logic mv, logic [4:0] mrd, logic [31:0] mval,
    logic ar, logic mr, logic we, logic [4:0] xrd,
    logic [31:0] xval, logic src);
    vec_t v;
    v.r = r; v.av = av; v.ard = ard; v.aval = aval;
    v.mv = mv; v.mrd = mrd; v.mval = mval;
    v.ar = ar; v.mr = mr; v.we = we; v.rd = xrd; v.val = xval; v.src = src;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int mrd_n;
    int first_alu;
    logic ap, mp;
    logic [4:0] ard_r, mrd_r;
    logic [31:0] aval_r, mval_r;

    tbl.push_back(mk(1,1,5'd3,32'h11,1,5'd4,32'h22, 0,0,0,5'd0,32'h0,0));
    tbl.push_back(mk(1,1,5'd3,32'h11,1,5'd4,32'h22, 0,0,0,5'd0,32'h0,0));
    tbl.push_back(mk(0,1,5'd5,32'hDEADBEEF,0,5'd0,32'h0,
                     1,0,1,5'd5,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd0,32'h0,
                     0,0,0,5'd5,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd0,32'h1, 0,1,0,5'd0,32'h1,1));
    tbl.push_back(mk(0,1,5'd2,32'h55,1,5'd7,32'h1234,
                     0,1,1,5'd7,32'h1234,1));
    tbl.push_back(mk(0,1,5'd2,32'h55,0,5'd0,32'h0, 1,0,1,5'd2,32'h55,0));
    tbl.push_back(mk(0,1,5'd0,32'h9,0,5'd0,32'h0, 1,0,0,5'd0,32'h9,0));
    tbl.push_back(mk(1,1,5'd6,32'h66,1,5'd8,32'h88, 0,0,0,5'd0,32'h0,0));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd0,32'h0, 0,0,0,5'd0,32'h0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].av, tbl[i].ard, tbl[i].aval,
            tbl[i].mv, tbl[i].mrd, tbl[i].mval);
      chk($sformatf("tbl%0d.alu_ready", i), alu_ready, tbl[i].ar);
      chk($sformatf("tbl%0d.mem_ready", i), mem_ready, tbl[i].mr);
      tick();
      chk($sformatf("tbl%0d.write_en", i), write_en, tbl[i].we);
      chk($sformatf("tbl%0d.rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d.rd_val", i), rd_val, tbl[i].val);
      chk($sformatf("tbl%0d.wb_src", i), wb_src, tbl[i].src);
    end

    // Conflict: loads win four times, then the starved ALU, then a load.
    mrd_n = 1;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 5'd9, 32'hA9, 1, 5'(mrd_n), 32'(mrd_n * 16));
      chk($sformatf("conf%0d.alu_ready", c), alu_ready, c == 4);
      chk($sformatf("conf%0d.mem_ready", c), mem_ready, c != 4);
      tick();
      chk($sformatf("conf%0d.rd", c), rd,
          (c < 4) ? 5'(c + 1) : (c == 4) ? 5'd9 : 5'd5);
      chk($sformatf("conf%0d.wb_src", c), wb_src, c != 4);
      if (c != 4) mrd_n++;
    end
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();

    // Back-to-back loads keep write_en high with no bubble.
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 5'd0, 32'h0, 1, 5'(c + 3), 32'(c + 100));
      tick();
      chk($sformatf("b2b%0d.write_en", c), write_en, 1'b1);
      chk($sformatf("b2b%0d.rd", c), rd, 5'(c + 3));
      chk($sformatf("b2b%0d.rd_val", c), rd_val, 32'(c + 100));
    end
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();
    chk("b2b.idle_write_en", write_en, 1'b0);

    // Reset while the ALU has waited three cycles restarts its wait.
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
      tick();
    end
    drive(1, 1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
    chk("mid_rst.alu_ready", alu_ready, 1'b0);
    chk("mid_rst.mem_ready", mem_ready, 1'b0);
    tick();
    chk("mid_rst.write_en", write_en, 1'b0);
    first_alu = -1;
    for (int c = 0; c < 10 && first_alu < 0; c++) begin
      drive(0, 1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
      if (alu_ready) first_alu = c;
      tick();
    end
    chk("mid_rst.alu_grant_cycle", 64'(first_alu), 64'd4);
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();

    // Random traffic with stable-until-ready requesters.
    ap = 1'b0; mp = 1'b0;
    ard_r = '0; mrd_r = '0; aval_r = '0; mval_r = '0;
    for (int c = 0; c < 400; c++) begin
      logic r;
      r = ($urandom_range(0, 39) == 0);
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1'b1;
        ard_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        aval_r = $urandom;
      end
      if (!mp && $urandom_range(0, 2) != 0) begin
        mp = 1'b1;
        mrd_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        mval_r = $urandom;
      end
      drive(r, ap, ard_r, aval_r, mp, mrd_r, mval_r);
      chk("rnd.alu_ready", alu_ready, e_ar);
      chk("rnd.mem_ready", mem_ready, e_mr);
      if (e_ar) ap = 1'b0;
      if (e_mr) mp = 1'b0;
      tick();
      chk("rnd.write_en", write_en, m_we);
      chk("rnd.rd", rd, m_rd);
      chk("rnd.rd_val", rd_val, m_val);
      chk("rnd.wb_src", wb_src, m_src);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
